// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: front-panel button handling for a single-step CPU harness.
//
// Ports
//   CCLK        : sole clock, rising edge
//   rst         : asynchronous active-high reset
//   BTNN        : raw north button, single-step request
//   BTNE        : raw east button, CPU reset request
//   BTNS        : raw south button, display page advance
//   BTNW        : raw west button, run/step mode toggle
//   step_en     : pipeline clock enable for the CPU core
//   cpu_rst     : synchronous reset to the CPU core
//   run_mode    : 1 = free-run, 0 = single-step
//   disp_page   : display page select (wraps 3 -> 0)
//   step_count  : step_en cycles since the last CPU reset (wraps)
//
// Each button goes through a 2-flop synchronizer, a per-button debounce
// counter and a rising-edge detector (btn_db). The control logic consumes
// the one-cycle press pulses; all outputs are registered.

module btn_db #(
  parameter int DB_CNT = 2
) (
  input  logic CCLK,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam logic [7:0] DB_W = 8'(DB_CNT);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       db_q, db_d;
  logic       db_dly_q, db_dly_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    cnt_d    = 8'd0;
    cnt_inc  = cnt_q + 8'd1;
    // Count consecutive disagreeing cycles; flip and restart on reaching DB_CNT.
    if (s2_q != db_q) begin
      if (cnt_inc == DB_W) begin
        db_d  = ~db_q;
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  // High for exactly the first cycle the debounced level is 1.
  assign press = db_q & ~db_dly_q;
endmodule

module btn_step_ctrl #(
  parameter int DB_CNT   = 2,
  parameter int RST_HOLD = 4
) (
  input  logic        CCLK,
  input  logic        rst,
  input  logic        BTNN,
  input  logic        BTNE,
  input  logic        BTNS,
  input  logic        BTNW,
  output logic        step_en,
  output logic        cpu_rst,
  output logic        run_mode,
  output logic [1:0]  disp_page,
  output logic [15:0] step_count
);
  localparam int         NB     = 4;
  localparam int         B_N    = 0;
  localparam int         B_E    = 1;
  localparam int         B_S    = 2;
  localparam int         B_W    = 3;
  localparam logic [7:0] HOLD_W = 8'(RST_HOLD);

  logic [NB-1:0] raw;
  logic [NB-1:0] press;

  assign raw = {BTNW, BTNS, BTNE, BTNN};

  genvar g;
  generate
    for (g = 0; g < NB; g++) begin : g_btn
      btn_db #(.DB_CNT(DB_CNT)) u_db (
        .CCLK  (CCLK),
        .rst   (rst),
        .raw   (raw[g]),
        .press (press[g])
      );
    end
  endgenerate

  logic [7:0]  hold_q, hold_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        step_en_q, step_en_d;
  logic        run_mode_q, run_mode_d;
  logic [1:0]  disp_page_q, disp_page_d;
  logic [15:0] step_count_q, step_count_d;

  always_comb begin
    hold_d = hold_q;
    if (press[B_E])
      hold_d = HOLD_W;          // a press while holding reloads the hold
    else if (hold_q != 8'd0)
      hold_d = hold_q - 8'd1;
    cpu_rst_d = (hold_d != 8'd0);

    // Mode in effect is the current registered one, so a toggle reaches
    // step_en one cycle after run_mode changes. Reset masks everything,
    // including a north press arriving together with an east press.
    step_en_d = ~cpu_rst_d & (run_mode_q | press[B_N]);

    run_mode_d  = run_mode_q ^ press[B_W];
    disp_page_d = disp_page_q + {1'b0, press[B_S]};

    // Cleared in the same cycle cpu_rst rises, so the count reads 0 for
    // the whole hold.
    step_count_d = cpu_rst_d ? 16'd0 : step_count_q + {15'd0, step_en_q};
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      hold_q       <= HOLD_W;
      cpu_rst_q    <= 1'b1;
      step_en_q    <= 1'b0;
      run_mode_q   <= 1'b0;
      disp_page_q  <= 2'd0;
      step_count_q <= 16'd0;
    end else begin
      hold_q       <= hold_d;
      cpu_rst_q    <= cpu_rst_d;
      step_en_q    <= step_en_d;
      run_mode_q   <= run_mode_d;
      disp_page_q  <= disp_page_d;
      step_count_q <= step_count_d;
    end
  end

  assign step_en    = step_en_q;
  assign cpu_rst    = cpu_rst_q;
  assign run_mode   = run_mode_q;
  assign disp_page  = disp_page_q;
  assign step_count = step_count_q;
endmodule

// File: tb/tb_btn_step_ctrl.sv
// Testbench for btn_step_ctrl: behavioural model compared every cycle,
// directed scenarios with hand-computed expectations, randomized buttons
// with occasional mid-stream resets, and a full step_count wrap in run mode.

module tb_btn_step_ctrl;
  localparam int DB_CNT   = 2;
  localparam int RST_HOLD = 4;

  logic        CCLK = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  btn  = 4'b0;   // {W,S,E,N}
  logic        step_en, cpu_rst, run_mode;
  logic [1:0]  disp_page;
  logic [15:0] step_count;

  btn_step_ctrl #(.DB_CNT(DB_CNT), .RST_HOLD(RST_HOLD)) dut (
    .CCLK       (CCLK),
    .rst        (rst),
    .BTNN       (btn[0]),
    .BTNE       (btn[1]),
    .BTNS       (btn[2]),
    .BTNW       (btn[3]),
    .step_en    (step_en),
    .cpu_rst    (cpu_rst),
    .run_mode   (run_mode),
    .disp_page  (disp_page),
    .step_count (step_count)
  );

  always #5 CCLK = ~CCLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // ---------------- behavioural model ----------------
  // Raw levels reach the debouncer two cycles late; a debounced level flips
  // after DB_CNT consecutive disagreeing samples; a press is the cycle after
  // a 0->1 flip and is acted on at the following edge.
  bit [3:0] m_s1, m_s2, m_db, m_press;
  int       m_run [4];
  int       m_hold, m_page, m_cnt;
  bit       m_rst_o, m_step, m_mode;
  bit       m_step_nx, m_old;
  int       m_cnt_nx;

  always @(posedge CCLK or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      m_hold = RST_HOLD; m_rst_o = 1; m_step = 0; m_mode = 0;
      m_page = 0; m_cnt = 0;
    end else begin
      if (m_press[1]) m_hold = RST_HOLD;
      else if (m_hold > 0) m_hold = m_hold - 1;
      m_step_nx = (m_hold == 0) && (m_mode || m_press[0]);
      m_cnt_nx  = (m_hold > 0) ? 0 : (m_cnt + int'(m_step)) % 65536;
      m_mode    = m_mode ^ m_press[3];
      m_page    = (m_page + int'(m_press[2])) % 4;
      m_rst_o   = (m_hold > 0);
      m_step    = m_step_nx;
      m_cnt     = m_cnt_nx;
      for (int b = 0; b < 4; b++) begin
        m_old = m_db[b];
        if (m_s2[b] != m_db[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DB_CNT) begin
            m_db[b]  = ~m_db[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_press[b] = m_db[b] & ~m_old;
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CCLK) begin
    if (chk_en) begin
      n_chk++;
      if ({step_en, cpu_rst, run_mode, disp_page, step_count} !==
          {m_step, m_rst_o, m_mode, 2'(m_page), 16'(m_cnt)}) begin
        n_fail++;
        $display("FAIL model t=%0t got en=%b rst=%b mode=%b page=%0d cnt=%h exp en=%b rst=%b mode=%b page=%0d cnt=%h",
                 $time, step_en, cpu_rst, run_mode, disp_page, step_count,
                 m_step, m_rst_o, m_mode, m_page, 16'(m_cnt));
      end
    end
  end

  int n_steps = 0;
  always @(negedge CCLK) if (chk_en && step_en === 1'b1) n_steps++;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CCLK); #2; end
  endtask

  task automatic press_btn(input int b, input int hi, input int lo);
    btn[b] = 1'b1; cyc(hi);
    btn[b] = 1'b0; cyc(lo);
  endtask

  int pat, hi_cnt, first, bad, s0, saw_rst, saw_wrap;
  logic [15:0] prev_cnt;
  int page_exp [5] = '{1, 2, 3, 0, 1};

  initial begin
    // reset state
    cyc(3);
    @(negedge CCLK);
    chk_en = 1;
    check("reset_outputs", {step_en, cpu_rst, run_mode, disp_page, step_count}, 21'h080000);
    @(posedge CCLK); #2; rst = 0;
    pat = 0; hi_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CCLK);
      if (cpu_rst) begin pat |= (1 << k); hi_cnt++; end
    end
    check("rst_hold_cycles", hi_cnt, 4);
    check("rst_hold_pattern", pat, 'b0000001111);

    // 24 clean north presses in step mode
    cyc(1);
    s0 = n_steps;
    for (int i = 0; i < 24; i++) press_btn(0, 4, 6);
    cyc(4);
    check("step24_count", step_count, 24);
    check("step24_pulses", n_steps - s0, 24);
    check("step24_mode", run_mode, 0);

    // one-cycle glitch is filtered
    press_btn(0, 1, 10);
    check("glitch_count", step_count, 24);

    // 4-cycle high: step_en exactly 5 cycles after the raw rise
    btn[0] = 1'b1; first = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge CCLK);
      if (step_en && first < 0) first = k;
      if (k == 3) begin @(posedge CCLK); #2; btn[0] = 1'b0; end
    end
    check("north_latency", first, 5);
    cyc(2);

    // south pages, with an east press between presses
    for (int i = 0; i < 5; i++) begin
      press_btn(2, 4, 6);
      check($sformatf("page_%0d", i), disp_page, page_exp[i]);
      if (i == 1) begin
        press_btn(1, 4, 8);
        check("page_after_east", disp_page, 2);
      end
    end

    // run mode for 100 cycles, then an east press
    press_btn(3, 4, 100);
    check("run_mode_on", run_mode, 1);
    check("run_step_en", step_en, 1);
    btn[1] = 1'b1; hi_cnt = 0; bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CCLK);
      if (cpu_rst) begin
        hi_cnt++;
        if (step_en || step_count != 0) bad++;
      end
      if (k == 3) begin @(posedge CCLK); #2; btn[1] = 1'b0; end
    end
    check("east_hold_cycles", hi_cnt, 4);
    check("east_hold_quiet", bad, 0);
    check("run_resumed", step_en, 1);

    // back to step mode, then east and north rise together
    press_btn(3, 4, 10);
    check("step_mode_back", run_mode, 0);
    btn[0] = 1'b1; btn[1] = 1'b1; s0 = n_steps; saw_rst = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CCLK);
      if (cpu_rst) saw_rst = 1;
      if (k == 3) begin @(posedge CCLK); #2; btn[0] = 1'b0; btn[1] = 1'b0; end
    end
    check("east_north_rst", saw_rst, 1);
    check("east_north_steps", n_steps - s0, 0);
    check("east_north_count", step_count, 0);

    // randomized buttons with occasional mid-stream resets
    for (int k = 0; k < 2000; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) btn[b] = ~btn[b];
      if ($urandom_range(399) == 0) begin
        rst = 1'b1; cyc($urandom_range(1, 3)); rst = 1'b0;
      end
      cyc(1);
    end
    btn = 4'b0;
    cyc(10);

    // full wrap in run mode
    rst = 1'b1; cyc(2); rst = 1'b0;
    cyc(6);
    press_btn(3, 4, 4);
    saw_wrap = 0; prev_cnt = step_count;
    for (int k = 0; k < 66000 && !saw_wrap; k++) begin
      @(negedge CCLK);
      if (prev_cnt == 16'hFFFF && step_count == 16'h0000 && !cpu_rst) saw_wrap = 1;
      prev_cnt = step_count;
    end
    check("count_wrap", saw_wrap, 1);
    @(negedge CCLK);
    check("after_wrap", step_count, 1);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/btn_step_ctrl.md
BTN_STEP_CTRL -- requirements
Module: btn_step_ctrl

Interface
REQ-001 Parameter DB_CNT, default 2: consecutive CCLK cycles a synchronized button level must differ from its debounced state before that state flips; legal range 1..255.
REQ-002 Parameter RST_HOLD, default 4: CCLK cycles cpu_rst stays asserted after a BTNE press; legal range 1..255.
REQ-003 CCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 BTNN  input  1  raw north button; single-step request.
REQ-006 BTNE  input  1  raw east button; CPU reset request.
REQ-007 BTNS  input  1  raw south button; display-page advance.
REQ-008 BTNW  input  1  raw west button; run/step mode toggle.
REQ-009 step_en  output  1  pipeline clock enable for the CPU core.
REQ-010 cpu_rst  output  1  synchronous reset to the CPU core.
REQ-011 run_mode  output  1  1 = free-run, 0 = single-step.
REQ-012 disp_page  output  2  LCD/LED page select for the display stage.
REQ-013 step_count  output  16  number of step_en cycles since the last CPU reset.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each button SHALL have its own debounce counter: increments while the synchronized level differs from the debounced state; clears when they are equal; when it reaches DB_CNT, the debounced state flips and the counter clears in the same cycle.
REQ-016 Each debounced state SHALL drive a rising-edge detector producing a press pulse exactly one CCLK cycle wide; falling edges produce nothing.
REQ-017 Latency: raw edge to press pulse SHALL be exactly 2 + DB_CNT cycles for a clean, bounce-free input.
REQ-018 East press: cpu_rst SHALL assert the following cycle and hold for RST_HOLD cycles. A new east press while cpu_rst is high SHALL reload the hold counter to RST_HOLD.
REQ-019 step_count SHALL clear to 0 every cycle cpu_rst is high.
REQ-020 While cpu_rst is high, step_en SHALL be 0 regardless of mode or north press.
REQ-021 Step mode (run_mode=0): a north press SHALL produce exactly one step_en cycle, the cycle after the press pulse.
REQ-022 Run mode (run_mode=1): step_en SHALL be 1 every cycle cpu_rst is 0; north presses are ignored.
REQ-023 A west press SHALL toggle run_mode the following cycle; a change of run_mode takes effect on step_en in the next cycle.
REQ-024 A south press SHALL increment disp_page by 1, wrapping 3 -> 0; cpu_rst SHALL NOT affect disp_page.
REQ-025 step_count SHALL increment by 1 on every step_en cycle, wrapping 0xFFFF -> 0x0000 with no flag.
REQ-026 Simultaneous events: east and north press in the same cycle -> reset wins, no step_en; east and west in the same cycle -> both take effect (mode toggles and cpu_rst asserts).
REQ-027 Buttons SHALL be independent: any combination of presses in one cycle is handled per REQ-018..REQ-026 with no lost pulses.

Reset
REQ-028 rst high SHALL asynchronously force: all synchronizer flops, debounced states and debounce counters to 0; step_en=0, cpu_rst=1, run_mode=0, disp_page=0, step_count=0. The RST_HOLD counter is loaded to RST_HOLD.
REQ-029 After rst deasserts, cpu_rst SHALL remain 1 for RST_HOLD cycles and then drop to 0.
REQ-030 A button held high across rst deassertion SHALL NOT produce a press pulse until it has been debounced high, i.e. only after 2 + DB_CNT cycles; a pulse then fires once.
REQ-031 rst asserted mid-debounce or mid-hold SHALL abandon the operation completely; no stale pulse emerges after release.

Verification
REQ-032 rst pulse, then idle 10 cycles (RST_HOLD=4) -> cpu_rst high for exactly 4 cycles after release, all other outputs 0.
REQ-033 Step mode, 24 clean north presses, each high 3+ cycles -> exactly 24 single-cycle step_en pulses, step_count=24, run_mode=0.
REQ-034 North glitch 1 cycle wide (DB_CNT=2) -> no step_en, step_count unchanged; a 4-cycle high on north -> one step_en exactly 5 cycles after the raw rise.
REQ-035 West press, run 100 cycles, east press -> step_en high continuously, step_count climbs, then cpu_rst high 4 cycles, step_count=0 and step_en=0 during the hold, step_en resumes afterwards.
REQ-036 South pressed 5 times -> disp_page sequence 1,2,3,0,1; east press between presses leaves disp_page unchanged.
REQ-037 East and north raw rises in the same cycle -> cpu_rst asserts, no step_en, step_count=0; preload step_count=0xFFFF in run mode -> next step wraps it to 0x0000.
